key_tone_synth: RTL and testbench
=================================

Name: key_tone_synth

Overview:
- Sits directly downstream of the music-keys controller and consumes its 6-bit key-pressed vector.
- Builds one square-wave voice per key using a phase accumulator, and mixes the active voices into an 8-bit unsigned audio sample at a fixed sample rate.
- Drives that sample out as a 1-bit PWM signal for the board's audio GPIO.
- Also presents the sample and a valid strobe, so a later recording stage can capture it.

Parameters:
- SAMPLE_DIV, 1136: clocks per sample tick; 50 MHz / 1136 ≈ 44.014 kHz.
- ACC_BITS, 24: width of each phase accumulator.
- AMP, 21: per-voice amplitude. 6*AMP must be ≤127.
- INC0, 99728: phase increment for key 0 (C4, 261.63 Hz).
- INC1, 111938: key 1 (D4).
- INC2, 125649: key 2 (E4).
- INC3, 133121: key 3 (F4).
- INC4, 149423: key 4 (G4).
- INC5, 167719: key 5 (A4).

Ports:
- clock_50Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high = synth allowed to sound. Driven from state decode.
- key_pressed  in  6  active-high key vector from the music-keys controller; bit n = key n.
- sample_out  out  8  unsigned mixed sample; 128 = silence.
- sample_valid  out  1  one-cycle strobe, high when sample_out has just updated.
- voices_active  out  3  count of keys latched at the last tick (0..6).
- pwm_out  out  1  PWM audio output.

Behaviour:
- All state changes on the rising edge of clock_50Mhz. Reset is sampled only on that edge.
- Reset values: tick counter 0; all accumulators 0; latched keys 0; sample_out 128; sample_valid 0; voices_active 0; PWM counter 0; PWM compare 128; pwm_out 0.
- Reset asserted mid-operation: everything returns to the reset values on the next edge. The tick counter restarts.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (count == SAMPLE_DIV-1).
  - The first tick occurs on the edge at cycle SAMPLE_DIV-1 after reset release, counting the first released cycle as 0.
- Pipeline stage 1 (on the tick edge):
  - latched_keys <= key_pressed & {6{enable}}.
  - For each voice n: if the new latched bit is 1, acc[n] <= acc[n] + INCn, modulo 2^ACC_BITS (wrap silently). Otherwise acc[n] <= 0, so every note starts at phase 0.
- Key changes between ticks are ignored: a key pulse that does not overlap a tick edge produces no sound.
- Pipeline stage 2 (the edge one cycle after the tick):
  - Each enabled voice contributes +AMP if acc[n] MSB = 0, and -AMP if MSB = 1. Disabled voices contribute 0.
  - Compute the signed sum, range -126..+126.
  - sample_out <= sum + 128, with no saturation required by construction.
  - voices_active <= popcount(latched_keys).
  - PWM compare <= the same value as sample_out.
- sample_valid is high for exactly one cycle: the cycle following the stage-2 edge. Period = SAMPLE_DIV clocks.
- sample_out and voices_active hold their values between strobes.
- PWM:
  - The 8-bit counter free-runs every clock and wraps 255→0.
  - pwm_out <= (pwm_cnt < compare), registered.
  - High-count per 256-clock period equals compare. Silence gives a 50% duty cycle.
- enable = 0 behaves exactly like all keys released: the accumulators clear at the next tick, and sample_out becomes 128 at the following stage-2 edge.
- Single-cycle latency from tick to sample. No backpressure: the consumer must take the sample on the strobe.

Test Plan:
- Sim overrides: SAMPLE_DIV=4, ACC_BITS=8, INC0=64.
- Key 0 held, enable=1 -> successive sample_out on the strobes: 149, 107, 107, 149, then repeating; voices_active=1.
- No keys, or enable=0 with all keys held -> sample_out=128 and voices_active=0 on every strobe. pwm_out is high for exactly 128 of every 256 clocks.
- All six keys held, each INCn=1 (MSB stays 0 for the first 127 ticks) -> sample_out=254, voices_active=6. With sample_out=254, pwm_out is high for 254 of 256 clocks.
- key_pressed pulses high for 1 cycle at tick counter=1, never covering a tick -> sample_out stays 128, accumulators stay 0.
- Reset pulse of 1 cycle while key 0 sounds -> next cycle sample_out=128, sample_valid=0. After release, the first sample_valid arrives at cycle SAMPLE_DIV (=4) and sample_out=149.
- ACC_BITS=8, INC0=200, key 0 held -> accumulator sequence 200, 144, 88, 32, 232, wrapping modulo 256. Samples: 107, 107, 149, 149, 107.

Source files
------------

// File: rtl/key_tone_synth.sv
// Six-voice square-wave key synthesizer: per-key phase accumulators, a fixed-rate
// sample mixer producing an 8-bit unsigned sample, and a PWM stage for the audio pin.
module key_tone_synth #(
  parameter int SAMPLE_DIV = 1136,
  parameter int ACC_BITS   = 24,
  parameter int AMP        = 21,
  parameter int INC0       = 99728,
  parameter int INC1       = 111938,
  parameter int INC2       = 125649,
  parameter int INC3       = 133121,
  parameter int INC4       = 149423,
  parameter int INC5       = 167719
) (
  input  logic       clock_50Mhz,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] key_pressed,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic [2:0] voices_active,
  output logic       pwm_out
);

  localparam int CNT_BITS = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(SAMPLE_DIV - 1);
  localparam logic signed [8:0] AMP_S = 9'(AMP);
  localparam logic [ACC_BITS-1:0] INC_V [6] = '{
    ACC_BITS'(INC0), ACC_BITS'(INC1), ACC_BITS'(INC2),
    ACC_BITS'(INC3), ACC_BITS'(INC4), ACC_BITS'(INC5)
  };

  logic [CNT_BITS-1:0] tickCnt;
  logic                tick;
  logic                tickDly;
  logic [5:0]          nextKeys;
  logic [5:0]          latchedKeys;
  logic [ACC_BITS-1:0] acc [6];
  logic signed [8:0]   mixSum;
  logic signed [8:0]   biased;
  logic [2:0]          popCnt;
  logic [7:0]          sampleNext;
  logic [7:0]          pwmCnt;
  logic [7:0]          pwmCmp;

  assign tick     = (tickCnt == LAST_COUNT);
  assign nextKeys = key_pressed & {6{enable}};

  // Stage-2 mix reads the accumulators and keys that stage 1 just wrote.
  always_comb begin
    mixSum = '0;
    popCnt = '0;
    for (int n = 0; n < 6; n++) begin
      if (latchedKeys[n]) begin
        mixSum = acc[n][ACC_BITS-1] ? (mixSum - AMP_S) : (mixSum + AMP_S);
        popCnt = popCnt + 3'd1;
      end
    end
    biased = mixSum + 9'sd128;
  end

  assign sampleNext = biased[7:0];

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      tickCnt     <= '0;
      tickDly     <= 1'b0;
      latchedKeys <= '0;
      for (int n = 0; n < 6; n++) begin
        acc[n] <= '0;
      end
    end else begin
      tickCnt <= tick ? '0 : (tickCnt + CNT_BITS'(1));
      tickDly <= tick;
      if (tick) begin
        latchedKeys <= nextKeys;
        // A released voice parks at phase 0 so the next press starts cleanly.
        for (int n = 0; n < 6; n++) begin
          acc[n] <= nextKeys[n] ? (acc[n] + INC_V[n]) : '0;
        end
      end
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      sample_out    <= 8'd128;
      sample_valid  <= 1'b0;
      voices_active <= 3'd0;
      pwmCmp        <= 8'd128;
    end else begin
      sample_valid <= tickDly;
      if (tickDly) begin
        sample_out    <= sampleNext;
        voices_active <= popCnt;
        pwmCmp        <= sampleNext;
      end
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      pwmCnt  <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwmCnt  <= pwmCnt + 8'd1;
      pwm_out <= (pwmCnt < pwmCmp);
    end
  end

endmodule

// File: tb/tb_key_tone_synth.sv
// Bench for key_tone_synth: three small-parameter instances share stimulus and are
// compared against a tick-level arithmetic model of the voices and mixer.
module tb_key_tone_synth;

  localparam int DIV = 4;
  localparam int AMP = 21;
  localparam int INC_TAB [3][6] = '{
    '{64,  111938, 125649, 133121, 149423, 167719},
    '{1,   1,      1,      1,      1,      1},
    '{200, 111938, 125649, 133121, 149423, 167719}
  };

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] keyPressed;
  logic [7:0] smp    [3];
  logic       valid  [3];
  logic [2:0] voices [3];
  logic       pwm    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_tone_synth #(.SAMPLE_DIV(DIV), .ACC_BITS(8), .INC0(64)) dut0 (
    .clock_50Mhz(clk), .reset(reset), .enable(enable), .key_pressed(keyPressed),
    .sample_out(smp[0]), .sample_valid(valid[0]), .voices_active(voices[0]), .pwm_out(pwm[0])
  );

  key_tone_synth #(.SAMPLE_DIV(DIV), .ACC_BITS(8), .INC0(1), .INC1(1), .INC2(1),
                   .INC3(1), .INC4(1), .INC5(1)) dut1 (
    .clock_50Mhz(clk), .reset(reset), .enable(enable), .key_pressed(keyPressed),
    .sample_out(smp[1]), .sample_valid(valid[1]), .voices_active(voices[1]), .pwm_out(pwm[1])
  );

  key_tone_synth #(.SAMPLE_DIV(DIV), .ACC_BITS(8), .INC0(200)) dut2 (
    .clock_50Mhz(clk), .reset(reset), .enable(enable), .key_pressed(keyPressed),
    .sample_out(smp[2]), .sample_valid(valid[2]), .voices_active(voices[2]), .pwm_out(pwm[2])
  );

  // Reference: cyc is the index of the upcoming edge since reset release; a tick edge
  // advances every pressed voice by its increment mod 256 and queues the mixed sample.
  int cyc = 0;
  int macc [3][6];
  logic [10:0] expQ0 [$];
  logic [10:0] expQ1 [$];
  logic [10:0] expQ2 [$];

  always @(posedge clk) begin : refModel
    int na [3][6];
    logic [5:0] k;
    int s;
    int v;
    if (reset) begin
      cyc <= 0;
      for (int c = 0; c < 3; c++)
        for (int n = 0; n < 6; n++) macc[c][n] <= 0;
      expQ0.delete();
      expQ1.delete();
      expQ2.delete();
    end else begin
      for (int c = 0; c < 3; c++)
        for (int n = 0; n < 6; n++) na[c][n] = macc[c][n];
      if (cyc % DIV == DIV - 1) begin
        k = keyPressed & {6{enable}};
        for (int c = 0; c < 3; c++) begin
          s = 128;
          v = 0;
          for (int n = 0; n < 6; n++) begin
            if (k[n]) begin
              na[c][n] = (na[c][n] + INC_TAB[c][n]) % 256;
              s = s + ((na[c][n] >= 128) ? -AMP : AMP);
              v = v + 1;
            end else begin
              na[c][n] = 0;
            end
          end
          if (c == 0) expQ0.push_back({v[2:0], s[7:0]});
          else if (c == 1) expQ1.push_back({v[2:0], s[7:0]});
          else expQ2.push_back({v[2:0], s[7:0]});
        end
      end
      for (int c = 0; c < 3; c++)
        for (int n = 0; n < 6; n++) macc[c][n] <= na[c][n];
      cyc <= cyc + 1;
    end
  end

  function automatic logic [10:0] popExp(int c);
    logic [10:0] r;
    r = 11'h7ff;
    if (c == 0 && expQ0.size() > 0) r = expQ0.pop_front();
    if (c == 1 && expQ1.size() > 0) r = expQ1.pop_front();
    if (c == 2 && expQ2.size() > 0) r = expQ2.pop_front();
    return r;
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the number of negedges waited until the strobe, or -1 on timeout.
  task automatic waitStrobe(output int n);
    n = -1;
    for (int i = 1; i <= 4 * DIV; i++) begin
      @(negedge clk);
      if (valid[0] === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countPwm(input int c, output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm[c] === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    keyPressed = 6'($urandom_range(1, 63));
    enable = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (smp[c] !== 8'd128) begin errors++; $display("FAIL reset_sample cfg%0d got %0d expected 128", c, smp[c]); end
      checks++;
      if (valid[c] !== 1'b0) begin errors++; $display("FAIL reset_valid cfg%0d got %b expected 0", c, valid[c]); end
      checks++;
      if (voices[c] !== 3'd0) begin errors++; $display("FAIL reset_voices cfg%0d got %0d expected 0", c, voices[c]); end
      checks++;
      if (pwm[c] !== 1'b0) begin errors++; $display("FAIL reset_pwm cfg%0d got %b expected 0", c, pwm[c]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_key0();
    int n;
    logic [10:0] e;
    int tab0 [4] = '{149, 107, 107, 149};
    int tab2 [5] = '{107, 107, 149, 149, 107};
    keyPressed = 6'b000001;
    enable = 1'b1;
    applyReset();
    for (int j = 0; j < 8; j++) begin
      waitStrobe(n);
      checks++;
      if (n != ((j == 0) ? DIV + 1 : DIV)) begin errors++; $display("FAIL key0_timing strobe%0d got %0d cycles expected %0d", j, n, (j == 0) ? DIV + 1 : DIV); end
      checks++;
      if (smp[0] !== 8'(tab0[j % 4])) begin errors++; $display("FAIL key0_inc64 strobe%0d got %0d expected %0d", j, smp[0], tab0[j % 4]); end
      if (j < 5) begin
        checks++;
        if (smp[2] !== 8'(tab2[j])) begin errors++; $display("FAIL key0_inc200 strobe%0d got %0d expected %0d", j, smp[2], tab2[j]); end
      end
      checks++;
      if (voices[0] !== 3'd1) begin errors++; $display("FAIL key0_voices strobe%0d got %0d expected 1", j, voices[0]); end
      for (int c = 0; c < 3; c++) begin
        e = popExp(c);
        checks++;
        if ({voices[c], smp[c]} !== e) begin errors++; $display("FAIL key0_model cfg%0d got v=%0d s=%0d expected v=%0d s=%0d", c, voices[c], smp[c], e[10:8], e[7:0]); end
      end
    end
  endtask

  task automatic test_silence();
    int n;
    int hi;
    logic [10:0] e;
    for (int phase = 0; phase < 2; phase++) begin
      keyPressed = (phase == 0) ? 6'b000000 : 6'b111111;
      enable = (phase == 0);
      applyReset();
      for (int j = 0; j < 3; j++) begin
        waitStrobe(n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL silence_strobe phase%0d got timeout expected strobe", phase); end
        for (int c = 0; c < 3; c++) begin
          e = popExp(c);
          checks++;
          if (smp[c] !== 8'd128 || voices[c] !== 3'd0) begin errors++; $display("FAIL silence_value phase%0d cfg%0d got v=%0d s=%0d expected v=0 s=128", phase, c, voices[c], smp[c]); end
          checks++;
          if ({voices[c], smp[c]} !== e) begin errors++; $display("FAIL silence_model phase%0d cfg%0d got v=%0d s=%0d expected v=%0d s=%0d", phase, c, voices[c], smp[c], e[10:8], e[7:0]); end
        end
      end
      countPwm(0, hi);
      checks++;
      if (hi != 128) begin errors++; $display("FAIL silence_pwm phase%0d got %0d high expected 128", phase, hi); end
    end
  endtask

  task automatic test_all_keys();
    int n;
    int hi;
    logic [10:0] e;
    keyPressed = 6'b111111;
    enable = 1'b1;
    applyReset();
    for (int j = 0; j < 3; j++) begin
      waitStrobe(n);
      checks++;
      if (smp[1] !== 8'd254 || voices[1] !== 3'd6) begin errors++; $display("FAIL all_keys_value strobe%0d got v=%0d s=%0d expected v=6 s=254", j, voices[1], smp[1]); end
      for (int c = 0; c < 3; c++) begin
        e = popExp(c);
        checks++;
        if ({voices[c], smp[c]} !== e) begin errors++; $display("FAIL all_keys_model cfg%0d got v=%0d s=%0d expected v=%0d s=%0d", c, voices[c], smp[c], e[10:8], e[7:0]); end
      end
    end
    @(negedge clk);
    countPwm(1, hi);
    checks++;
    if (hi != 254) begin errors++; $display("FAIL all_keys_pwm got %0d high expected 254", hi); end
  endtask

  task automatic test_short_pulse();
    int n;
    logic [10:0] e;
    keyPressed = 6'b000000;
    enable = 1'b1;
    applyReset();
    waitStrobe(n);
    void'(popExp(0)); void'(popExp(1)); void'(popExp(2));
    for (int i = 0; i < 2 * DIV && (cyc % DIV) != 1; i++) @(negedge clk);
    keyPressed = 6'($urandom_range(1, 63));
    @(negedge clk);
    keyPressed = 6'b000000;
    for (int j = 0; j < 3; j++) begin
      waitStrobe(n);
      for (int c = 0; c < 3; c++) begin
        e = popExp(c);
        checks++;
        if (smp[c] !== 8'd128 || {voices[c], smp[c]} !== e) begin errors++; $display("FAIL pulse_silent cfg%0d got s=%0d expected s=128 model s=%0d", c, smp[c], e[7:0]); end
      end
    end
    // A clean phase-0 start proves the pulse left the accumulators untouched.
    keyPressed = 6'b000001;
    waitStrobe(n);
    checks++;
    if (smp[0] !== 8'd149) begin errors++; $display("FAIL pulse_phase0 got %0d expected 149", smp[0]); end
    keyPressed = 6'b000000;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [10:0] e;
    keyPressed = 6'b000001;
    enable = 1'b1;
    applyReset();
    for (int j = 0; j < 3; j++) waitStrobe(n);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (smp[c] !== 8'd128 || valid[c] !== 1'b0) begin errors++; $display("FAIL mid_reset cfg%0d got s=%0d valid=%b expected s=128 valid=0", c, smp[c], valid[c]); end
    end
    reset = 1'b0;
    waitStrobe(n);
    checks++;
    if (n != DIV + 1) begin errors++; $display("FAIL mid_reset_latency got %0d cycles expected %0d", n, DIV + 1); end
    checks++;
    if (smp[0] !== 8'd149) begin errors++; $display("FAIL mid_reset_sample got %0d expected 149", smp[0]); end
    for (int c = 0; c < 3; c++) begin
      e = popExp(c);
      checks++;
      if ({voices[c], smp[c]} !== e) begin errors++; $display("FAIL mid_reset_model cfg%0d got v=%0d s=%0d expected v=%0d s=%0d", c, voices[c], smp[c], e[10:8], e[7:0]); end
    end
  endtask

  task automatic test_random();
    localparam int CYC = 200;
    int strobes;
    logic prevValid;
    logic [10:0] e;
    keyPressed = 6'($urandom_range(0, 63));
    enable = 1'b1;
    applyReset();
    strobes = 0;
    prevValid = 1'b0;
    for (int i = 0; i < CYC; i++) begin
      @(negedge clk);
      if (valid[0] === 1'b1) begin
        strobes++;
        checks++;
        if (prevValid) begin errors++; $display("FAIL random_valid_width cycle%0d got 2-cycle strobe expected 1", i); end
        for (int c = 0; c < 3; c++) begin
          e = popExp(c);
          checks++;
          if ({voices[c], smp[c]} !== e || valid[c] !== 1'b1) begin errors++; $display("FAIL random_model cfg%0d got v=%0d s=%0d expected v=%0d s=%0d", c, voices[c], smp[c], e[10:8], e[7:0]); end
        end
      end
      prevValid = valid[0];
      if ($urandom_range(0, 2) == 0) begin
        keyPressed = 6'($urandom_range(0, 63));
        enable = ($urandom_range(0, 3) != 0);
      end
    end
    checks++;
    if (strobes != (CYC - 1) / DIV) begin errors++; $display("FAIL random_strobe_count got %0d expected %0d", strobes, (CYC - 1) / DIV); end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    keyPressed = 6'b000000;
    @(negedge clk);
    test_reset();
    test_key0();
    test_silence();
    test_all_keys();
    test_short_pulse();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
